// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/predictor bundle for the branch resolve unit.
// Master drives pushes and resolves; slave is the unit itself.
interface branch_resolve_unit_if #(
    parameter int PC_W = 32
);
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            pred_ready;
    logic            res_valid;
    logic            res_taken;
    logic [PC_W-1:0] res_target;
    logic            upd_valid;
    logic [3:0]      upd_index;
    logic            upd_taken;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;
    logic            q_empty;
    logic [15:0]     branch_count;
    logic [15:0]     mispredict_count;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target,
        output res_valid, res_taken, res_target,
        input  pred_ready, upd_valid, upd_index, upd_taken,
        input  flush, redirect_pc, q_empty,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target,
        input  res_valid, res_taken, res_target,
        output pred_ready, upd_valid, upd_index, upd_taken,
        output flush, redirect_pc, q_empty,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order branch prediction queue resolved against execute outcomes;
// emits predictor updates, mispredict flush/redirect and statistics.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input logic                 clk,
    input logic                 rst,
    branch_resolve_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0] q_pc  [DEPTH];
    logic [PC_W-1:0] q_tgt [DEPTH];
    logic            q_tk  [DEPTH];

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            upd_valid;
    logic [3:0]      upd_index;
    logic            upd_taken;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;
    logic [15:0]     branch_count;
    logic [15:0]     mispredict_count;

    logic            ready;
    logic            resolve;
    logic            mispredict;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_tgt;
    logic            head_tk;

    assign ready    = (count != CW'(DEPTH));
    assign head_pc  = q_pc[rd_ptr];
    assign head_tgt = q_tgt[rd_ptr];
    assign head_tk  = q_tk[rd_ptr];

    assign resolve = bus.res_valid && (count != '0);
    assign mispredict = resolve &&
        ((head_tk != bus.res_taken) ||
         (bus.res_taken && (head_tgt != bus.res_target)));
    // A push alongside a mispredict is on the wrong path.
    assign push = bus.pred_valid && ready && !mispredict;
    assign pop  = resolve && !mispredict;

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]  <= bus.pred_pc;
            q_tgt[wr_ptr] <= bus.pred_target;
            q_tk[wr_ptr]  <= bus.pred_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            upd_valid        <= 1'b0;
            upd_index        <= '0;
            upd_taken        <= 1'b0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            upd_valid <= resolve;
            flush     <= mispredict;
            if (resolve) begin
                upd_index <= head_pc[3:0];
                upd_taken <= bus.res_taken;
                if (branch_count != 16'hFFFF)
                    branch_count <= branch_count + 16'd1;
            end
            if (mispredict) begin
                redirect_pc <= bus.res_taken ? bus.res_target
                                             : head_pc + PC_W'(4);
                if (mispredict_count != 16'hFFFF)
                    mispredict_count <= mispredict_count + 16'd1;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign bus.pred_ready       = ready;
    assign bus.upd_valid        = upd_valid;
    assign bus.upd_index        = upd_index;
    assign bus.upd_taken        = upd_taken;
    assign bus.flush            = flush;
    assign bus.redirect_pc      = redirect_pc;
    assign bus.q_empty          = (count == '0);
    assign bus.branch_count     = branch_count;
    assign bus.mispredict_count = mispredict_count;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: push/resolve sequences,
// mispredict flush, full queue, empty resolve and mid-run reset.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    branch_resolve_unit_if #(.PC_W(32)) bus ();

    branch_resolve_unit #(.DEPTH(4), .PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_push(input logic v, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt);
        bus.pred_valid  = v;
        bus.pred_pc     = pc;
        bus.pred_taken  = tk;
        bus.pred_target = tgt;
    endtask

    task automatic set_res(input logic v, input logic tk,
                           input logic [31:0] tgt);
        bus.res_valid  = v;
        bus.res_taken  = tk;
        bus.res_target = tgt;
    endtask

    initial begin
        set_push(0, 0, 0, 0);
        set_res(0, 0, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_upd_valid", 32'(bus.upd_valid), 0);
        chk("rst_upd_index", 32'(bus.upd_index), 0);
        chk("rst_upd_taken", 32'(bus.upd_taken), 0);
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_redirect", bus.redirect_pc, 0);
        chk("rst_q_empty", 32'(bus.q_empty), 1);
        chk("rst_ready", 32'(bus.pred_ready), 1);
        chk("rst_bc", 32'(bus.branch_count), 0);
        chk("rst_mc", 32'(bus.mispredict_count), 0);

        // correct taken prediction
        set_push(1, 32'h100, 1, 32'h200);
        step();
        chk("t1_q_nonempty", 32'(bus.q_empty), 0);
        set_push(0, 0, 0, 0);
        set_res(1, 1, 32'h200);
        step();
        set_res(0, 0, 0);
        chk("t1_upd_valid", 32'(bus.upd_valid), 1);
        chk("t1_upd_index", 32'(bus.upd_index), 0);
        chk("t1_upd_taken", 32'(bus.upd_taken), 1);
        chk("t1_flush", 32'(bus.flush), 0);
        chk("t1_bc", 32'(bus.branch_count), 1);
        chk("t1_mc", 32'(bus.mispredict_count), 0);
        chk("t1_q_empty", 32'(bus.q_empty), 1);
        step();
        chk("t1_upd_pulse", 32'(bus.upd_valid), 0);

        // direction mispredict: predicted NT, actually taken
        set_push(1, 32'h104, 0, 32'h0);
        step();
        set_push(0, 0, 0, 0);
        set_res(1, 1, 32'h300);
        step();
        set_res(0, 0, 0);
        chk("t2_flush", 32'(bus.flush), 1);
        chk("t2_redirect", bus.redirect_pc, 32'h300);
        chk("t2_upd_taken", 32'(bus.upd_taken), 1);
        chk("t2_upd_index", 32'(bus.upd_index), 4);
        chk("t2_mc", 32'(bus.mispredict_count), 1);
        chk("t2_bc", 32'(bus.branch_count), 2);
        step();
        chk("t2_flush_pulse", 32'(bus.flush), 0);
        chk("t2_redirect_hold", bus.redirect_pc, 32'h300);

        // predicted taken, actually not taken
        set_push(1, 32'h108, 1, 32'h500);
        step();
        set_push(0, 0, 0, 0);
        set_res(1, 0, 32'h0);
        step();
        set_res(0, 0, 0);
        chk("t2b_flush", 32'(bus.flush), 1);
        chk("t2b_redirect", bus.redirect_pc, 32'h10C);
        chk("t2b_upd_taken", 32'(bus.upd_taken), 0);
        chk("t2b_upd_index", 32'(bus.upd_index), 8);
        chk("t2b_mc", 32'(bus.mispredict_count), 2);
        step();

        // fill queue, refuse extra pushes
        for (int i = 0; i < 4; i++) begin
            set_push(1, 32'h110 + 32'(4 * i), 1, 32'h600);
            step();
        end
        chk("t3_full_ready", 32'(bus.pred_ready), 0);
        set_push(1, 32'h120, 1, 32'h600);
        step();
        chk("t3_still_full", 32'(bus.pred_ready), 0);
        // pop while full: push presented at same edge is refused
        set_push(1, 32'h124, 1, 32'h600);
        set_res(1, 1, 32'h600);
        step();
        chk("t3_pop_bc", 32'(bus.branch_count), 4);
        chk("t3_pop_flush", 32'(bus.flush), 0);
        chk("t3_ready_after_pop", 32'(bus.pred_ready), 1);
        // mispredict head 0x114 with 3 queued and a push presented
        set_push(1, 32'h130, 1, 32'h700);
        set_res(1, 0, 32'h0);
        step();
        chk("t3_sq_flush", 32'(bus.flush), 1);
        chk("t3_sq_redirect", bus.redirect_pc, 32'h118);
        chk("t3_sq_q_empty", 32'(bus.q_empty), 1);
        chk("t3_sq_mc", 32'(bus.mispredict_count), 3);
        chk("t3_sq_bc", 32'(bus.branch_count), 5);
        // push during flush cycle is accepted
        set_push(1, 32'h140, 0, 32'h0);
        set_res(0, 0, 0);
        step();
        chk("t3_flush_push", 32'(bus.q_empty), 0);
        // push and correct resolve together
        set_push(1, 32'h144, 0, 32'h0);
        set_res(1, 0, 32'h0);
        step();
        chk("t3_pp_flush", 32'(bus.flush), 0);
        chk("t3_pp_redirect_hold", bus.redirect_pc, 32'h118);
        chk("t3_pp_index", 32'(bus.upd_index), 0);
        chk("t3_pp_q_empty", 32'(bus.q_empty), 0);
        set_push(0, 0, 0, 0);
        set_res(1, 0, 32'h0);
        step();
        chk("t3_b2b_valid", 32'(bus.upd_valid), 1);
        chk("t3_b2b_index", 32'(bus.upd_index), 4);
        chk("t3_b2b_q_empty", 32'(bus.q_empty), 1);
        chk("t3_b2b_bc", 32'(bus.branch_count), 7);
        set_res(0, 0, 0);
        step();

        // target mismatch
        set_push(1, 32'h150, 1, 32'h400);
        step();
        set_push(0, 0, 0, 0);
        set_res(1, 1, 32'h404);
        step();
        set_res(0, 0, 0);
        chk("t4_flush", 32'(bus.flush), 1);
        chk("t4_redirect", bus.redirect_pc, 32'h404);
        chk("t4_mc", 32'(bus.mispredict_count), 4);
        chk("t4_bc", 32'(bus.branch_count), 8);
        step();

        // resolve on empty queue, push still accepted
        set_push(1, 32'h160, 0, 32'h0);
        set_res(1, 1, 32'h900);
        step();
        set_res(0, 0, 0);
        chk("t5_upd_valid", 32'(bus.upd_valid), 0);
        chk("t5_flush", 32'(bus.flush), 0);
        chk("t5_bc", 32'(bus.branch_count), 8);
        chk("t5_mc", 32'(bus.mispredict_count), 4);
        chk("t5_push_taken", 32'(bus.q_empty), 0);
        set_push(1, 32'h164, 0, 32'h0);
        step();
        set_push(0, 0, 0, 0);

        // async reset with two queued entries
        rst = 1'b1;
        #1;
        chk("t6_q_empty", 32'(bus.q_empty), 1);
        chk("t6_flush", 32'(bus.flush), 0);
        chk("t6_bc", 32'(bus.branch_count), 0);
        step();
        rst = 1'b0;
        set_res(1, 0, 32'h0);
        step();
        set_res(0, 0, 0);
        chk("t6_no_upd", 32'(bus.upd_valid), 0);
        chk("t6_no_flush", 32'(bus.flush), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolves in-flight branch predictions against execute-stage outcomes and closes the loop back to the two-bit predictor table. Sits between fetch, which pushes each predicted branch in program order, and execute, which reports actual direction and target in the same order. The unit produces table-update strobes for the predictor, a one-cycle flush/redirect on misprediction, and saturating branch and mispredict statistics.

## Interface
- DEPTH, 4: in-flight branch queue entries; power of two, 2..16.
- PC_W, 32: PC and target width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pred_valid  in  1  fetch pushes one predicted branch this cycle.
- pred_pc  in  PC_W  PC of the predicted branch.
- pred_taken  in  1  predicted direction (1 = taken).
- pred_target  in  PC_W  predicted target; meaningful only when pred_taken = 1.
- pred_ready  out  1  queue not full; a push is accepted only when pred_valid & pred_ready.
- res_valid  in  1  execute resolves the oldest queued branch this cycle.
- res_taken  in  1  actual direction.
- res_target  in  PC_W  actual taken target.
- upd_valid  out  1  predictor table update strobe; registered, one cycle.
- upd_index  out  4  table index, equal to pc[3:0] of the resolved branch.
- upd_taken  out  1  actual outcome to train the 2-bit counter.
- flush  out  1  mispredict flush; registered, one cycle.
- redirect_pc  out  PC_W  correct next PC; valid while flush = 1.
- q_empty  out  1  no branches in flight.
- branch_count  out  16  resolved branches; saturates at 0xFFFF.
- mispredict_count  out  16  mispredicted branches; saturates at 0xFFFF.

## Operation
- Queue: circular FIFO of DEPTH entries {pc, taken, target}, with read pointer, write pointer, and occupancy count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- pred_ready = (count != DEPTH). It depends only on registered state, so a full queue refuses a push even when a pop occurs in the same cycle.
- Resolve when res_valid = 1 and the queue is non-empty:
  - Pop the head entry.
  - Register upd_valid = 1, upd_index = head.pc[3:0], upd_taken = res_taken.
  - Increment branch_count, saturating.
- Mispredict when head.taken != res_taken, or when both are 1 and head.target != res_target. On mispredict:
  - Register flush = 1.
  - Register redirect_pc = res_target if res_taken, otherwise head.pc + 4 (modulo 2^PC_W).
  - Increment mispredict_count, saturating.
  - Squash the whole queue: pointers to 0, count to 0.
  - Drop any push presented in the same cycle, since it is a wrong-path branch.
- Correct prediction: pop only. flush stays 0 and redirect_pc holds its previous value.
- res_valid with an empty queue is ignored: no update, no count change, no flush. A push in that cycle is still accepted.
- A push and a non-mispredicting resolve in the same cycle: both take effect and count is unchanged.
- A push is accepted during the cycle flush = 1. It belongs to the redirected path.
- Reset: queue empty, pointers 0, upd_valid = 0, upd_index = 0, upd_taken = 0, flush = 0, redirect_pc = 0, both counters 0, q_empty = 1, pred_ready = 1. Reset asserted mid-operation discards all in-flight entries immediately; no flush is emitted for them.

## Timing
- Resolve sampled at edge N: upd_* and flush/redirect_pc are valid during cycle N+1 and are high for exactly one cycle unless another resolve occurs at edge N+1.
- Back-to-back resolves every cycle are supported, with one update per cycle.
- Counters and q_empty reflect the edge-N state during cycle N+1.
- A push at edge N is eligible for resolve at edge N+1.
- No combinational path from any res_* or pred_* input to any output.

## Test plan
- Reset then idle: all outputs at reset values; q_empty = 1, pred_ready = 1, counters 0.
- Push pc=0x100 taken, target=0x200; resolve taken, target=0x200 next cycle → one upd_valid with upd_index=0x0, upd_taken=1; flush=0; branch_count=1; mispredict_count=0.
- Push pc=0x104 not-taken; resolve taken, target=0x300 → flush=1 for one cycle, redirect_pc=0x300, upd_taken=1, upd_index=0x4, mispredict_count=1. Then push pc=0x108 taken; resolve not-taken → redirect_pc=0x10C.
- Fill the queue with 4 pushes → pred_ready=0 and a 5th push is ignored. Mispredict the head while 3 entries are still queued and a push is presented → q_empty=1 next cycle and the push is dropped.
- Push taken target=0x400; resolve taken target=0x404 → target mismatch: flush=1, redirect_pc=0x404.
- Resolve on an empty queue → no upd_valid, no flush, counters unchanged. Assert rst with 2 entries queued → q_empty=1 immediately, flush stays 0.
